// File: rtl/odd_sched_pkg.sv
// Shared types and constants for the odd-number sequence scheduler.
package odd_sched_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    localparam int unsigned ODD_START = 1;
    localparam int unsigned ODD_STEP  = 2;

endpackage

// File: rtl/odd_step_gen.sv
// Odd-value datapath register: holds the current odd value, steps by two, restarts at one.
module odd_step_gen
    import odd_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] val_o
);

    logic [WIDTH-1:0] val_q, val_d;

    // Clear wins over step; the add wraps naturally modulo 2**WIDTH.
    always_comb begin
        val_d = val_q;
        if (clear_i) begin
            val_d = WIDTH'(ODD_START);
        end else if (step_i) begin
            val_d = val_q + WIDTH'(ODD_STEP);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q <= WIDTH'(ODD_START);
        end else begin
            val_q <= val_d;
        end
    end

    assign val_o = val_q;

endmodule

// File: rtl/odd_seq_sched.sv
// Round-robin scheduler streaming bursts of consecutive odd values to N_REQ requesters.
module odd_seq_sched
    import odd_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*LEN_W-1:0]   len_i,
    input  logic                     clear_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] id_o,
    output logic [WIDTH-1:0]         cnt_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     last_o,
    output logic                     busy_o
);

    localparam int unsigned IdW = $clog2(N_REQ);

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IdW-1:0]     id_q, id_d;
    logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               clear_pend_q, clear_pend_d;

    logic               win_found;
    logic [IdW-1:0]     win_id;
    logic [LEN_W-1:0]   win_len;
    logic               gen_step;
    logic               gen_clear;

    // Search starts just past the last winner so every requester gets its turn.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            if (!win_found && req_i[(int'(rr_ptr_q) + i) % int'(N_REQ)]) begin
                win_found = 1'b1;
                win_id    = IdW'((int'(rr_ptr_q) + i) % int'(N_REQ));
            end
        end
        win_len = len_i[win_id*LEN_W +: LEN_W];
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        id_d         = id_q;
        rr_ptr_d     = rr_ptr_q;
        rem_d        = rem_q;
        clear_pend_d = clear_pend_q;
        gen_step     = 1'b0;
        gen_clear    = 1'b0;
        unique case (state_q)
            IDLE: begin
                gen_clear = clear_i;
                if (win_found) begin
                    state_d  = BURST;
                    gnt_d    = N_REQ'(1) << win_id;
                    id_d     = win_id;
                    rr_ptr_d = win_id;
                    rem_d    = (win_len == '0) ? LEN_W'(1) : win_len;
                end
            end
            BURST: begin
                // A clear during a burst is deferred so the burst stays contiguous.
                clear_pend_d = clear_pend_q | clear_i;
                if (ready_i) begin
                    gen_step = 1'b1;
                    rem_d    = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d      = IDLE;
                        gnt_d        = '0;
                        gen_clear    = clear_i | clear_pend_q;
                        clear_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            id_q         <= '0;
            rr_ptr_q     <= IdW'(N_REQ - 1);
            rem_q        <= '0;
            clear_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            id_q         <= id_d;
            rr_ptr_q     <= rr_ptr_d;
            rem_q        <= rem_d;
            clear_pend_q <= clear_pend_d;
        end
    end

    odd_step_gen #(
        .WIDTH(WIDTH)
    ) u_gen (
        .clk    (clk),
        .reset  (reset),
        .step_i (gen_step),
        .clear_i(gen_clear),
        .val_o  (cnt_o)
    );

    assign valid_o = (state_q == BURST);
    assign busy_o  = (state_q == BURST);
    assign last_o  = (state_q == BURST) && (rem_q == LEN_W'(1));
    assign gnt_o   = gnt_q;
    assign id_o    = id_q;

endmodule

// File: tb/tb_odd_seq_sched.sv
// Randomized and directed bench for odd_seq_sched against a beat-counting reference model.
module tb_odd_seq_sched;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int LW = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         req_i;
    logic [N*LW-1:0]      len_i;
    logic                 clear_i;
    logic [N-1:0]         gnt_o;
    logic [$clog2(N)-1:0] id_o;
    logic [W-1:0]         cnt_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 last_o;
    logic                 busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: m_k counts odd values consumed since the last clear.
    bit m_active;
    bit m_pend;
    int m_owner;
    int m_left;
    int m_k;
    int m_ptr;

    always #5 clk = ~clk;

    odd_seq_sched #(
        .N_REQ(N),
        .WIDTH(W),
        .LEN_W(LW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req_i  (req_i),
        .len_i  (len_i),
        .clear_i(clear_i),
        .gnt_o  (gnt_o),
        .id_o   (id_o),
        .cnt_o  (cnt_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .last_o (last_o),
        .busy_o (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_cnt();
        return (2 * m_k + 1) % (1 << W);
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_pend   = 1'b0;
        m_owner  = 0;
        m_left   = 0;
        m_k      = 0;
        m_ptr    = N - 1;
    endtask

    task automatic model_advance(input logic [N-1:0] req, input logic [N*LW-1:0] len_v,
                                 input logic clr, input logic rdy);
        int l;
        if (!m_active) begin
            if (clr) m_k = 0;
            if (req != '0) begin
                for (int i = 1; i <= N; i++) begin
                    if (req[(m_ptr + i) % N]) begin
                        m_owner = (m_ptr + i) % N;
                        break;
                    end
                end
                m_ptr    = m_owner;
                l        = int'(len_v[m_owner*LW +: LW]);
                m_left   = (l == 0) ? 1 : l;
                m_active = 1'b1;
            end
        end else begin
            if (rdy) begin
                m_k++;
                m_left--;
            end
            if (rdy && m_left == 0) begin
                m_active = 1'b0;
                if (clr || m_pend) m_k = 0;
                m_pend = 1'b0;
            end else if (clr) begin
                m_pend = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check("valid", 32'(valid_o), 32'(m_active));
        check("busy", 32'(busy_o), 32'(m_active));
        check("gnt", 32'(gnt_o), m_active ? (32'(1) << m_owner) : 32'(0));
        if (m_active) check("id", 32'(id_o), 32'(m_owner));
        check("last", 32'(last_o), 32'(m_active && m_left == 1));
        check("cnt", 32'(cnt_o), 32'(exp_cnt()));
    endtask

    task automatic step(input logic [N-1:0] req, input logic [N*LW-1:0] len_v,
                        input logic clr, input logic rdy);
        req_i   = req;
        len_i   = len_v;
        clear_i = clr;
        ready_i = rdy;
        @(posedge clk);
        #1;
        model_advance(req, len_v, clr, rdy);
        check_outputs();
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req_i   = '0;
        len_i   = '0;
        clear_i = 1'b0;
        ready_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_ids[5];
        int beats;

        exp_ids = '{0, 1, 2, 3, 0};

        // Reset state
        do_reset();
        check("rst_valid", 32'(valid_o), 0);
        check("rst_gnt", 32'(gnt_o), 0);
        check("rst_id", 32'(id_o), 0);
        check("rst_cnt", 32'(cnt_o), 1);
        check("rst_last", 32'(last_o), 0);
        check("rst_busy", 32'(busy_o), 0);

        // Single requester, len 3
        step(4'b0001, 16'h0003, 1'b0, 1'b1);
        check("t1_b0", 32'(cnt_o), 1);
        check("t1_gnt", 32'(gnt_o), 1);
        step(4'b0001, 16'h0003, 1'b0, 1'b1);
        check("t1_b1", 32'(cnt_o), 3);
        step(4'b0000, 16'h0003, 1'b0, 1'b1);
        check("t1_b2", 32'(cnt_o), 5);
        check("t1_last", 32'(last_o), 1);
        step(4'b0000, 16'h0003, 1'b0, 1'b1);
        check("t1_idle", 32'(valid_o), 0);

        // Round-robin, all len 1
        do_reset();
        for (int b = 0; b < 5; b++) begin
            step(4'b1111, 16'h1111, 1'b0, 1'b1);
            check("rr_id", 32'(id_o), 32'(exp_ids[b]));
            check("rr_cnt", 32'(cnt_o), 32'(2 * b + 1));
            step(4'b1111, 16'h1111, 1'b0, 1'b1);
        end

        // Backpressure on first beat
        step(4'b0000, 16'h0000, 1'b1, 1'b1);
        step(4'b0001, 16'h0002, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(4'b0000, 16'h0002, 1'b0, 1'b0);
            check("bp_hold", 32'(cnt_o), 1);
            check("bp_valid", 32'(valid_o), 1);
        end
        step(4'b0000, 16'h0002, 1'b0, 1'b1);
        check("bp_b1", 32'(cnt_o), 3);
        check("bp_last", 32'(last_o), 1);
        step(4'b0000, 16'h0002, 1'b0, 1'b1);

        // Wrap across repeated bursts
        step(4'b0000, 16'h0000, 1'b1, 1'b1);
        beats = 0;
        for (int c = 0; c < 400 && beats < 130; c++) begin
            step(4'b0001, 16'h000A, 1'b0, 1'b1);
            if (valid_o) begin
                beats++;
                check("wrap_odd", 32'(cnt_o[0]), 1);
                if (beats == 128) check("wrap_128", 32'(cnt_o), 255);
                if (beats == 129) check("wrap_129", 32'(cnt_o), 1);
            end
        end
        if (beats < 130) check("wrap_beats", 32'(beats), 130);
        for (int c = 0; c < 40 && valid_o; c++) step(4'b0000, 16'h0000, 1'b0, 1'b1);

        // Clear mid-burst
        step(4'b0000, 16'h0000, 1'b1, 1'b1);
        step(4'b0001, 16'h0002, 1'b0, 1'b1);
        step(4'b0000, 16'h0002, 1'b0, 1'b1);
        step(4'b0000, 16'h0002, 1'b0, 1'b1);
        step(4'b0001, 16'h0004, 1'b0, 1'b1);
        check("clr_b0", 32'(cnt_o), 5);
        step(4'b0000, 16'h0004, 1'b0, 1'b1);
        check("clr_b1", 32'(cnt_o), 7);
        step(4'b0000, 16'h0004, 1'b1, 1'b1);
        check("clr_b2", 32'(cnt_o), 9);
        step(4'b0000, 16'h0004, 1'b0, 1'b1);
        check("clr_b3", 32'(cnt_o), 11);
        step(4'b0000, 16'h0004, 1'b0, 1'b1);
        check("clr_idle", 32'(cnt_o), 1);
        step(4'b0001, 16'h0004, 1'b0, 1'b1);
        check("clr_next", 32'(cnt_o), 1);
        step(4'b0000, 16'h0004, 1'b0, 1'b1);

        // Asynchronous reset mid-burst
        reset = 1'b1;
        #1;
        check("arst_gnt", 32'(gnt_o), 0);
        check("arst_valid", 32'(valid_o), 0);
        check("arst_cnt", 32'(cnt_o), 1);
        check("arst_busy", 32'(busy_o), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(4'b1111, 16'h1111, 1'b0, 1'b1);
        check("arst_first", 32'(id_o), 0);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            step(N'($urandom), (N * LW)'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
